sort_stream: RTL and testbench
==============================

SORT_STREAM -- requirements
Module: sort_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sort-key width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, max words per frame (>=2).
REQ-003 SHALL have parameter TAG_W, default 8, payload width carried with each key.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: desc  in  1  order select (1 descending, 0 ascending), sampled on accepted s_sop.
REQ-007 SHALL have ports: s_valid/s_ready  in/out  1  input handshake; s_data  in  DATA_W; s_tag  in  TAG_W; s_sop/s_eop  in  1  frame markers.
REQ-008 SHALL have ports: m_valid/m_ready  out/in  1  output handshake; m_data  out  DATA_W; m_tag  out  TAG_W; m_sop/m_eop  out  1.
REQ-009 SHALL have ports: err  out  1  one-cycle pulse on truncation or restart.

Function
REQ-010 SHALL transfer a word only when valid and ready are both high on the same edge.
REQ-011 SHALL implement FSM IDLE -> LOAD -> DRAIN -> IDLE.
REQ-012 IDLE: s_ready=1. Accepted word without s_sop SHALL be discarded. Accepted s_sop word SHALL be stored, latch desc, set count=1, go LOAD (or DRAIN if s_eop also set).
REQ-013 LOAD: s_ready=1. Each accepted word SHALL be inserted into the sorted register array in that cycle, count+1.
REQ-014 Insertion SHALL be stable: equal keys leave in arrival order.
REQ-015 Accepted s_eop SHALL end LOAD -> DRAIN. First m_valid SHALL be the cycle after that edge.
REQ-016 When count reaches DEPTH without s_eop, the block SHALL go DRAIN, pulse err, and treat the next accepted word as IDLE input.
REQ-017 s_sop accepted in LOAD with count>0 SHALL discard stored words, pulse err, and restart the frame with that word.
REQ-018 DRAIN: s_ready=0. m_valid=1. The array head SHALL be presented, and the array SHALL shift on each handshake.
REQ-019 m_sop SHALL be high on the first drained word. m_eop SHALL be high on the last (count==1). A 1-word frame SHALL assert both.
REQ-020 Output SHALL hold stable while m_valid && !m_ready.
REQ-021 After the m_eop handshake the FSM SHALL go IDLE and s_ready SHALL return high the next cycle. There is no cut-through.
REQ-022 Count SHALL be $clog2(DEPTH+1) bits and SHALL never wrap.

Reset
REQ-023 rst SHALL force IDLE, count=0, s_ready=1, m_valid=0, m_sop=0, m_eop=0, err=0, m_data=0, m_tag=0.
REQ-024 rst mid-LOAD or mid-DRAIN SHALL abandon the frame silently, with no err pulse.
REQ-025 Array contents need not be cleared. Empty slots SHALL be marked invalid by per-slot valid bits.

Configuration
REQ-026 Macro SORT_STREAM_TAG_EN SHALL control tag storage.
REQ-027 With SORT_STREAM_TAG_EN defined, s_tag SHALL travel with its key.
REQ-028 Without SORT_STREAM_TAG_EN, no tag storage SHALL be built, m_tag SHALL be constant 0, and s_tag SHALL be ignored. The port list SHALL be unchanged.

Structure
REQ-029 Package sort_stream_pkg SHALL hold the FSM state enum and the word struct {key, tag}.
REQ-030 Sub-module sort_stream_cell SHALL hold one slot (valid, word). It SHALL take a compare-with-incoming result, a neighbour word and a shift/insert control.
REQ-031 sort_stream SHALL instantiate DEPTH cells in a generate loop and compute insert position from per-cell compare flags.

Verification
REQ-032 Ascending frame 5,3,9,1 (sop on 5, eop on 1), m_ready=1 -> out 1,3,5,9; m_sop on 1; m_eop on 9; first m_valid one cycle after eop edge.
REQ-033 desc=1, keys 4,4,7 with tags A,B,C -> out 7/C, 4/A, 4/B (stable); tags all 0 without SORT_STREAM_TAG_EN.
REQ-034 DEPTH=4, six words 8,2,6,4,1,3 without eop -> out 2,4,6,8, err pulse once; next s_sop word starts a new frame.
REQ-035 Single word 0xAA with sop+eop -> one output 0xAA with m_sop=m_eop=1; output backpressured 3 cycles -> data held unchanged.
REQ-036 rst asserted during DRAIN after 2 of 4 outputs -> next cycle m_valid=0, s_ready=1, err=0; a fresh frame 2,1 -> out 1,2.

Source files
------------

// File: rtl/sort_stream_pkg.sv
// Shared types for the streaming frame sorter.
// The word struct uses fixed maximum field widths. Each module keeps only
// the low DATA_W / TAG_W bits, so DATA_W and TAG_W must not exceed these maxima.
package sort_stream_pkg;

  localparam int KEY_MAX_W = 32;
  localparam int TAG_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Per-slot update command issued by the top to every cell
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,  // take the incoming word unconditionally (frame start)
    OP_INS   = 3'd2,  // sorted insert, driven by the compare flags
    OP_SHIFT = 3'd3,  // drain: take the word from the slot behind
    OP_CLR   = 3'd4   // mark slot empty
  } cell_op_e;

  typedef struct packed {
    logic [KEY_MAX_W-1:0] key;
    logic [TAG_MAX_W-1:0] tag;
  } word_t;

endpackage

// File: rtl/sort_stream_cell.sv
// One slot of the sorted register array: a valid bit plus a stored word.
// The cell does no comparing of its own. It receives the incoming-word compare result
// for itself and for the slot ahead of it, and uses them to decide whether
// it takes the new word, takes its front neighbour, or holds.
// Optional feature macro: SORT_STREAM_TAG_EN (tag storage built only when defined).
module sort_stream_cell
  import sort_stream_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  cell_op_e op_i,
  input  logic     cmp_i,       // incoming word belongs at or before this slot
  input  logic     cmp_prev_i,  // same flag for the slot ahead (0 for the head)
  input  word_t    in_word_i,
  input  word_t    prev_word_i,
  input  logic     prev_vld_i,
  input  word_t    next_word_i,
  input  logic     next_vld_i,
  output logic     vld_o,
  output word_t    word_o
);

  logic  vld_d, vld_q;
  word_t word_d, word_q;

  // Next slot contents for the requested operation
  always_comb begin
    vld_d  = vld_q;
    word_d = word_q;
    case (op_i)
      OP_LOAD: begin
        vld_d  = 1'b1;
        word_d = in_word_i;
      end
      OP_INS: begin
        if (cmp_i) begin
          if (cmp_prev_i) begin
            // insertion point is ahead of us: make room by taking the front word
            vld_d  = prev_vld_i;
            word_d = prev_word_i;
          end else begin
            // first slot where the new word belongs
            vld_d  = 1'b1;
            word_d = in_word_i;
          end
        end
      end
      OP_SHIFT: begin
        vld_d  = next_vld_i;
        word_d = next_word_i;
      end
      OP_CLR:  vld_d = 1'b0;
      default: ;
    endcase
  end

  // Only the valid bit is reset; stale words behind a clear valid are harmless
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

`ifdef SORT_STREAM_TAG_EN
  // Key and tag storage
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end
`else
  logic [KEY_MAX_W-1:0] key_q;

  // Key storage only; the tag field reads as zero
  always_ff @(posedge clk) begin
    key_q <= word_d.key;
  end

  assign word_q = '{key: key_q, tag: '0};

  logic unused_tag;
  assign unused_tag = ^word_d.tag;
`endif

  assign vld_o  = vld_q;
  assign word_o = word_q;

endmodule

// File: rtl/sort_stream.sv
// Streaming frame sorter: loads one frame into a sorted register array with
// a stable insert per accepted word, then drains it in order.
// IDLE -> LOAD -> DRAIN -> IDLE. Overfull frames and restarts pulse err.
// Optional feature macro: SORT_STREAM_TAG_EN (carry s_tag with each key).
module sort_stream
  import sort_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [TAG_W-1:0]  s_tag,
  input  logic              s_sop,
  input  logic              s_eop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [TAG_W-1:0]  m_tag,
  output logic              m_sop,
  output logic              m_eop,
  output logic              err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               desc_q, desc_d;
  logic               first_q, first_d;
  logic               err_q, err_d;
  cell_op_e           op_all;

  word_t              in_word;
  word_t              words  [DEPTH];
  word_t              prv_w  [DEPTH];
  word_t              nxt_w  [DEPTH];
  cell_op_e           ops    [DEPTH];
  logic [DEPTH-1:0]   vlds, cmp, prv_v, prv_c, nxt_v;

  logic s_acc, m_acc;
  assign s_acc = s_valid && s_ready;
  assign m_acc = m_valid && m_ready;

  // Incoming word widened to the shared word layout
  always_comb begin
    in_word     = '0;
    in_word.key = KEY_MAX_W'(s_data);
`ifdef SORT_STREAM_TAG_EN
    in_word.tag = TAG_MAX_W'(s_tag);
`endif
  end

  // Frame control: next state, count, latched order and error pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    first_d = first_q;
    err_d   = 1'b0;
    op_all  = OP_HOLD;
    case (state_q)
      ST_IDLE: begin
        // non-sop words are dropped here
        if (s_acc && s_sop) begin
          op_all  = OP_LOAD;
          desc_d  = desc;
          cnt_d   = CNT_W'(1);
          first_d = 1'b1;
          state_d = s_eop ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_acc) begin
          if (s_sop) begin
            // restart: the partial frame is thrown away
            op_all  = OP_LOAD;
            desc_d  = desc;
            cnt_d   = CNT_W'(1);
            first_d = 1'b1;
            err_d   = 1'b1;
            state_d = s_eop ? ST_DRAIN : ST_LOAD;
          end else begin
            op_all = OP_INS;
            cnt_d  = cnt_q + CNT_W'(1);
            if (s_eop) begin
              state_d = ST_DRAIN;
            end else if (cnt_q + CNT_W'(1) == CNT_W'(DEPTH)) begin
              // array full without an end marker: truncate
              state_d = ST_DRAIN;
              err_d   = 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (m_acc) begin
          op_all  = OP_SHIFT;
          cnt_d   = cnt_q - CNT_W'(1);
          first_d = 1'b0;
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and frame registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Slot array. Valid slots are packed from index 0, so cmp is 0..0 1..1
  // and the insert point is the first set flag. Strict compares put an
  // equal key behind existing ones, which keeps the sort stable.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign cmp[i] = !vlds[i] ||
                    (desc_q ? (words[i].key < in_word.key)
                            : (words[i].key > in_word.key));

    // frame start loads the head and empties every other slot
    assign ops[i] = (op_all == OP_LOAD && i != 0) ? OP_CLR : op_all;

    if (i == 0) begin : g_head
      assign prv_w[i] = '0;
      assign prv_v[i] = 1'b0;
      assign prv_c[i] = 1'b0;
    end else begin : g_body
      assign prv_w[i] = words[i-1];
      assign prv_v[i] = vlds[i-1];
      assign prv_c[i] = cmp[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign nxt_w[i] = '0;
      assign nxt_v[i] = 1'b0;
    end else begin : g_front
      assign nxt_w[i] = words[i+1];
      assign nxt_v[i] = vlds[i+1];
    end

    sort_stream_cell u_cell (
      .clk         (clk),
      .rst         (rst),
      .op_i        (ops[i]),
      .cmp_i       (cmp[i]),
      .cmp_prev_i  (prv_c[i]),
      .in_word_i   (in_word),
      .prev_word_i (prv_w[i]),
      .prev_vld_i  (prv_v[i]),
      .next_word_i (nxt_w[i]),
      .next_vld_i  (nxt_v[i]),
      .vld_o       (vlds[i]),
      .word_o      (words[i])
    );
  end

  // Outputs decode from registered state; data is forced to zero when idle
  assign s_ready = (state_q != ST_DRAIN);
  assign m_valid = (state_q == ST_DRAIN);
  assign m_sop   = m_valid && first_q;
  assign m_eop   = m_valid && (cnt_q == CNT_W'(1));
  assign m_data  = m_valid ? words[0].key[DATA_W-1:0] : '0;
  assign err     = err_q;

`ifdef SORT_STREAM_TAG_EN
  assign m_tag = m_valid ? words[0].tag[TAG_W-1:0] : '0;
`else
  assign m_tag = '0;

  logic unused_tag;
  assign unused_tag = ^s_tag;
`endif

endmodule

// File: tb/tb_sort_stream.sv
// Bench for sort_stream: frame table, hand-written corner sequences and a
// randomized phase checked against a queue-based frame/sort model.
module tb_sort_stream;

  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int TW  = 8;

  logic          clk = 1'b0;
  logic          rst, desc, s_valid, s_ready, s_sop, s_eop;
  logic          m_valid, m_ready, m_sop, m_eop, err;
  logic [DW-1:0] s_data, m_data;
  logic [TW-1:0] s_tag, m_tag;

  sort_stream #(.DATA_W(DW), .DEPTH(DEP), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .desc(desc),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
    .s_sop(s_sop), .s_eop(s_eop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
    .m_sop(m_sop), .m_eop(m_eop), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit rnd_rdy = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] t;
    logic       s;
    logic       e;
  } out_t;

  // monitor: a transfer seen at the falling edge completes on the next rising edge
  out_t out_q[$];
  int   err_seen = 0;
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) out_q.push_back({m_data, m_tag, m_sop, m_eop});
    if (!rst && err) err_seen++;
  end

  function automatic logic [7:0] xt(logic [7:0] t);
`ifdef SORT_STREAM_TAG_EN
    return t;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: frames of accepted words ----------------
  bit         md_load = 1'b0;
  bit         md_desc = 1'b0;
  logic [7:0] mk[$];
  logic [7:0] mt[$];
  out_t       exp_q[$];
  int         exp_err = 0;

  // stable sort by repeated pick of the earliest best key
  function automatic void model_emit();
    int n = mk.size();
    for (int o = 0; o < n; o++) begin
      int b = 0;
      for (int j = 1; j < mk.size(); j++)
        if (md_desc ? (mk[j] > mk[b]) : (mk[j] < mk[b])) b = j;
      exp_q.push_back({mk[b], xt(mt[b]), (o == 0), (o == n - 1)});
      mk.delete(b);
      mt.delete(b);
    end
    md_load = 1'b0;
  endfunction

  function automatic void model_accept(logic [7:0] k, logic [7:0] t, bit sp, bit ep, bit d);
    if (sp) begin
      if (md_load && mk.size() > 0) exp_err++;
      mk.delete();
      mt.delete();
      md_load = 1'b1;
      md_desc = d;
    end else if (!md_load) begin
      return;
    end
    mk.push_back(k);
    mt.push_back(t);
    if (ep) model_emit();
    else if (mk.size() == DEP) begin
      model_emit();
      exp_err++;
    end
  endfunction

  function automatic void model_reset();
    md_load = 1'b0;
    mk.delete();
    mt.delete();
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(logic [7:0] k, logic [7:0] t, bit sp, bit ep, bit d);
    bit rdy;
    int n = 0;
    s_valid = 1'b1; s_data = k; s_tag = t; s_sop = sp; s_eop = ep; desc = d;
    forever begin
      rdy = s_ready;
      tick();
      if (rdy) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 32'(n), 0);
        break;
      end
    end
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    if (rdy) model_accept(k, t, sp, ep, d);
  endtask

  task automatic wait_out(int target);
    int n = 0;
    while (out_q.size() < target && n < 400) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(out_q.size() >= target), 1);
  endtask

  // ---------------- frame table ----------------
  typedef struct packed {
    logic            desc;
    logic [3:0]      n;
    logic [7:0][7:0] k;
    logic [7:0][7:0] t;
    logic [7:0]      sop;
    logic [7:0]      eop;
    logic [3:0]      en;
    logic [3:0][7:0] ek;
    logic [3:0][7:0] et;
    logic [3:0]      eerr;
  } vec_t;

  localparam int NT = 6;
  vec_t tbl[NT];

  function automatic void setw(int i, int w, logic [7:0] k, logic [7:0] t, bit sp, bit ep);
    tbl[i].k[w] = k; tbl[i].t[w] = t; tbl[i].sop[w] = sp; tbl[i].eop[w] = ep;
    tbl[i].n = 4'(w + 1);
  endfunction

  function automatic void setx(int i, int j, logic [7:0] k, logic [7:0] t);
    tbl[i].ek[j] = k; tbl[i].et[j] = t;
    tbl[i].en = 4'(j + 1);
  endfunction

  initial begin
    int ob, eb, eb2;
    for (int i = 0; i < NT; i++) tbl[i] = '0;
    // ascending 5,3,9,1
    setw(0,0,5,1,1,0); setw(0,1,3,2,0,0); setw(0,2,9,3,0,0); setw(0,3,1,4,0,1);
    setx(0,0,1,4); setx(0,1,3,2); setx(0,2,5,1); setx(0,3,9,3);
    // descending, equal keys keep arrival order
    tbl[1].desc = 1;
    setw(1,0,4,8'hA,1,0); setw(1,1,4,8'hB,0,0); setw(1,2,7,8'hC,0,1);
    setx(1,0,7,8'hC); setx(1,1,4,8'hA); setx(1,2,4,8'hB);
    // overfull frame: truncated at DEPTH, trailing non-sop words dropped
    setw(2,0,8,1,1,0); setw(2,1,2,2,0,0); setw(2,2,6,3,0,0); setw(2,3,4,4,0,0);
    setw(2,4,1,5,0,0); setw(2,5,3,6,0,0);
    setx(2,0,2,2); setx(2,1,4,4); setx(2,2,6,3); setx(2,3,8,1); tbl[2].eerr = 1;
    // eop arriving exactly at DEPTH words: no error, stable descending
    tbl[3].desc = 1;
    setw(3,0,2,1,1,0); setw(3,1,9,2,0,0); setw(3,2,2,3,0,0); setw(3,3,9,4,0,1);
    setx(3,0,9,2); setx(3,1,9,4); setx(3,2,2,1); setx(3,3,2,3);
    // sop mid-frame restarts
    setw(4,0,7,1,1,0); setw(4,1,8,2,0,0); setw(4,2,3,3,1,0); setw(4,3,1,4,0,1);
    setx(4,0,1,4); setx(4,1,3,3); tbl[4].eerr = 1;
    // stray word in idle dropped, then sop+eop single word
    setw(5,0,5,1,0,0); setw(5,1,6,2,1,1);
    setx(5,0,6,2);

    // ---- reset state ----
    rst = 1; desc = 0; s_valid = 0; s_data = 0; s_tag = 0; s_sop = 0; s_eop = 0; m_ready = 1;
    tick(); tick();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sop",   m_sop,   0);
    chk("rst_m_eop",   m_eop,   0);
    chk("rst_err",     err,     0);
    chk("rst_m_data",  m_data,  0);
    chk("rst_m_tag",   m_tag,   0);
    rst = 0;
    tick();

    // ---- table frames ----
    for (int i = 0; i < NT; i++) begin
      ob = out_q.size();
      eb = err_seen;
      for (int w = 0; w < int'(tbl[i].n); w++) begin
        send(tbl[i].k[w], tbl[i].t[w], tbl[i].sop[w], tbl[i].eop[w], tbl[i].desc);
        if (tbl[i].eop[w]) chk($sformatf("t%0d_first_vld", i), m_valid, 1);
      end
      wait_out(ob + int'(tbl[i].en));
      tick(); tick(); tick();
      chk($sformatf("t%0d_count", i), 32'(out_q.size() - ob), 32'(tbl[i].en));
      for (int j = 0; j < int'(tbl[i].en) && ob + j < out_q.size(); j++) begin
        chk($sformatf("t%0d_key%0d", i, j), out_q[ob+j].d, tbl[i].ek[j]);
        chk($sformatf("t%0d_tag%0d", i, j), out_q[ob+j].t, xt(tbl[i].et[j]));
        chk($sformatf("t%0d_sop%0d", i, j), out_q[ob+j].s, 32'(j == 0));
        chk($sformatf("t%0d_eop%0d", i, j), out_q[ob+j].e, 32'(j == int'(tbl[i].en) - 1));
      end
      chk($sformatf("t%0d_err", i), 32'(err_seen - eb), tbl[i].eerr);
    end

    // ---- single word with output backpressure ----
    m_ready = 0;
    send(8'hAA, 8'h5A, 1, 1, 0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp%0d_valid", c), m_valid, 1);
      chk($sformatf("bp%0d_data", c), m_data, 8'hAA);
      chk($sformatf("bp%0d_tag", c), m_tag, xt(8'h5A));
      chk($sformatf("bp%0d_sop_eop", c), {m_sop, m_eop}, 2'b11);
      chk($sformatf("bp%0d_s_ready", c), s_ready, 0);
      if (c < 3) tick();
    end
    m_ready = 1;
    tick();
    chk("bp_done_valid", m_valid, 0);
    chk("bp_done_ready", s_ready, 1);

    // ---- reset in the middle of a drain ----
    m_ready = 0;
    ob = out_q.size();
    eb2 = err_seen;
    send(4, 0, 1, 0, 0); send(3, 0, 0, 0, 0); send(2, 0, 0, 0, 0); send(1, 0, 0, 1, 0);
    m_ready = 1;
    tick(); tick();
    m_ready = 0;
    rst = 1;
    model_reset();
    tick();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_err",   err,     0);
    rst = 0;
    m_ready = 1;
    tick();
    chk("pre_rst_outs", 32'(out_q.size() - ob), 2);
    if (out_q.size() - ob >= 2) chk("pre_rst_keys", {out_q[ob].d, out_q[ob+1].d}, 16'h0102);
    ob = out_q.size();
    send(2, 0, 1, 0, 0); send(1, 0, 0, 1, 0);
    wait_out(ob + 2);
    tick(); tick();
    chk("post_rst_count", 32'(out_q.size() - ob), 2);
    if (out_q.size() - ob >= 2) chk("post_rst_keys", {out_q[ob].d, out_q[ob+1].d}, 16'h0102);
    chk("rst_no_err", 32'(err_seen - eb2), 0);

    // ---- randomized frames against the model ----
    exp_q.delete();
    exp_err = 0;
    ob = out_q.size();
    eb = err_seen;
    rnd_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      bit d = 1'($urandom_range(0, 1));
      int len = $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0)
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, d);
      for (int w = 0; w < len; w++) begin
        bit sp = (w == 0) || ($urandom_range(0, 15) == 0);
        bit ep = (w == len - 1) && ($urandom_range(0, 3) != 0);
        send(8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), sp, ep, d);
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    // close any frame still loading
    send(8'($urandom_range(0, 255)), 8'h33, 1, 1, 0);
    wait_out(ob + exp_q.size());
    rnd_rdy = 1'b0;
    m_ready = 1;
    for (int c = 0; c < 6; c++) tick();
    chk("rnd_count", 32'(out_q.size() - ob), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && ob + j < out_q.size(); j++)
      chk($sformatf("rnd_out%0d", j), 32'(out_q[ob+j]), 32'(exp_q[j]));
    chk("rnd_err", 32'(err_seen - eb), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
